// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_pipe
// Purpose  : Three-stage pipelined floating-point adder/subtractor with
//            valid/ready handshake, round-toward-zero, denormal flush.
// Revision : 1.0 - initial pipelined release
// ============================================================================
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_data
);
    localparam int c_W  = 1 + EXP_W + MAN_W;
    localparam int c_MW = MAN_W + 4;       // hidden + mantissa + guard/round/sticky
    localparam int c_SW = MAN_W + 5;       // adder width including carry
    localparam int c_EE = EXP_W + 2;       // signed exponent working width
    localparam logic [EXP_W-1:0] c_EMAX = '1;

    logic w_adv;
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    // ---------------- S1: unpack, specials, swap, align ----------------
    logic               w_sa, w_sb;
    logic [EXP_W-1:0]   w_ea, w_eb;
    logic [MAN_W-1:0]   w_ma, w_mb;
    logic               w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_spec;
    logic [c_W-1:0]     w_spec_val;
    logic               w_swap, w_sl, w_ss;
    logic [EXP_W-1:0]   w_el, w_es;
    logic [MAN_W-1:0]   w_mlf, w_msf;
    logic [c_MW-1:0]    w_ml, w_ms, w_ms_al, w_mask;
    logic [31:0]        w_diff, w_shamt;

    always_comb begin
        w_sa    = in_a[c_W-1];
        w_sb    = in_b[c_W-1] ^ in_sub;
        w_ea    = in_a[c_W-2:MAN_W];
        w_eb    = in_b[c_W-2:MAN_W];
        w_ma    = (w_ea == '0) ? '0 : in_a[MAN_W-1:0];
        w_mb    = (w_eb == '0) ? '0 : in_b[MAN_W-1:0];
        w_nan_a = (w_ea == c_EMAX) && (w_ma != '0);
        w_nan_b = (w_eb == c_EMAX) && (w_mb != '0);
        w_inf_a = (w_ea == c_EMAX) && (w_ma == '0);
        w_inf_b = (w_eb == c_EMAX) && (w_mb == '0);
        w_spec  = w_nan_a | w_nan_b | w_inf_a | w_inf_b;

        if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sa != w_sb)))
            w_spec_val = {1'b0, c_EMAX, 1'b1, {(MAN_W-1){1'b0}}};
        else if (w_inf_a)
            w_spec_val = {w_sa, c_EMAX, {MAN_W{1'b0}}};
        else
            w_spec_val = {w_sb, c_EMAX, {MAN_W{1'b0}}};

        w_swap = {w_eb, w_mb} > {w_ea, w_ma};
        w_sl   = w_swap ? w_sb : w_sa;
        w_ss   = w_swap ? w_sa : w_sb;
        w_el   = w_swap ? w_eb : w_ea;
        w_es   = w_swap ? w_ea : w_eb;
        w_mlf  = w_swap ? w_mb : w_ma;
        w_msf  = w_swap ? w_ma : w_mb;
        w_ml   = {(w_el != '0), w_mlf, 3'b000};
        w_ms   = {(w_es != '0), w_msf, 3'b000};

        // Shifting by the full width clears S and folds all of it into sticky
        w_diff  = {{(32-EXP_W){1'b0}}, w_el} - {{(32-EXP_W){1'b0}}, w_es};
        w_shamt = (w_diff > c_MW) ? c_MW : w_diff;
        w_mask  = ~({c_MW{1'b1}} << w_shamt);
        w_ms_al = (w_ms >> w_shamt) | {{(c_MW-1){1'b0}}, |(w_ms & w_mask)};
    end

    logic               r1_valid, r1_spec, r1_sl, r1_zs, r1_sub;
    logic [c_W-1:0]     r1_spec_val;
    logic [EXP_W-1:0]   r1_el;
    logic [c_MW-1:0]    r1_ml, r1_ms;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid    <= 1'b0;
            r1_spec     <= 1'b0;
            r1_sl       <= 1'b0;
            r1_zs       <= 1'b0;
            r1_sub      <= 1'b0;
            r1_spec_val <= '0;
            r1_el       <= '0;
            r1_ml       <= '0;
            r1_ms       <= '0;
        end else if (w_adv) begin
            r1_valid    <= in_valid;
            r1_spec     <= w_spec;
            r1_sl       <= w_sl;
            r1_zs       <= w_sa & w_sb;
            r1_sub      <= w_sl ^ w_ss;
            r1_spec_val <= w_spec_val;
            r1_el       <= w_el;
            r1_ml       <= w_ml;
            r1_ms       <= w_ms_al;
        end
    end

    // ---------------- S2: magnitude add / subtract ----------------
    logic [c_SW-1:0] w_sum;
    assign w_sum = r1_sub ? ({1'b0, r1_ml} - {1'b0, r1_ms})
                          : ({1'b0, r1_ml} + {1'b0, r1_ms});

    logic               r2_valid, r2_spec, r2_sl, r2_zs;
    logic [c_W-1:0]     r2_spec_val;
    logic [EXP_W-1:0]   r2_el;
    logic [c_SW-1:0]    r2_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid    <= 1'b0;
            r2_spec     <= 1'b0;
            r2_sl       <= 1'b0;
            r2_zs       <= 1'b0;
            r2_spec_val <= '0;
            r2_el       <= '0;
            r2_sum      <= '0;
        end else if (w_adv) begin
            r2_valid    <= r1_valid;
            r2_spec     <= r1_spec;
            r2_sl       <= r1_sl;
            r2_zs       <= r1_zs;
            r2_spec_val <= r1_spec_val;
            r2_el       <= r1_el;
            r2_sum      <= w_sum;
        end
    end

    // ---------------- S3: normalise, truncate, pack ----------------
    logic [31:0]      w_lz;
    logic [c_EE-1:0]  w_exp;
    logic [MAN_W-1:0] w_man;
    logic             w_ovf, w_unf;
    logic [c_W-1:0]   w_res;

    always_comb begin
        w_lz = c_MW;
        for (int i = 0; i < c_MW; i++) begin
            if (r2_sum[i]) w_lz = 32'(c_MW - 1 - i);
        end

        if (r2_sum[c_SW-1]) begin
            w_exp = {2'b00, r2_el} + {{(c_EE-1){1'b0}}, 1'b1};
            w_man = r2_sum[c_SW-2:4];
        end else begin
            w_exp = {2'b00, r2_el} - w_lz[c_EE-1:0];
            w_man = MAN_W'((r2_sum[c_MW-1:0] << w_lz) >> 3);
        end

        // w_exp is two's complement: top bit set means it went negative
        w_ovf = !w_exp[c_EE-1] && (w_exp[c_EE-2:0] >= {1'b0, c_EMAX});
        w_unf = w_exp[c_EE-1] || (w_exp == '0);

        if (r2_spec)
            w_res = r2_spec_val;
        else if (r2_sum == '0)
            w_res = {r2_zs, {(c_W-1){1'b0}}};
        else if (w_ovf)
            w_res = {r2_sl, c_EMAX, {MAN_W{1'b0}}};
        else if (w_unf)
            w_res = {r2_sl, {(c_W-1){1'b0}}};
        else
            w_res = {r2_sl, w_exp[EXP_W-1:0], w_man};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (w_adv) begin
            out_valid <= r2_valid;
            if (r2_valid) out_data <= w_res;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_addsub_pipe
// Purpose  : Self-checking bench for fp_addsub_pipe against an exact-arithmetic
//            reference (single and half precision instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_sub, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_data;
    logic        h_valid, h_sub, h_ready, h_ovalid, h_oready;
    logic [15:0] h_a, h_b, h_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) u_dut_h (
        .clk(clk), .rst_n(rst_n),
        .in_valid(h_valid), .in_ready(h_ready),
        .in_a(h_a), .in_b(h_b), .in_sub(h_sub),
        .out_valid(h_ovalid), .out_ready(h_oready), .out_data(h_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic s, input int e, input logic [31:0] m,
                                         input int ew, input int mw);
        return (32'(s) << (ew + mw)) | (32'(e) << mw) | m;
    endfunction

    // Reference: exact integer sum of the two values, then truncate toward zero
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic sub, input int ew, input int mw);
        int          emax, ea, eb, p, er;
        logic        sa, sb, sr;
        logic [31:0] mmask, ma, mb;
        logic [319:0] va, vb, vr;
        emax  = (1 << ew) - 1;
        mmask = (32'd1 << mw) - 1;
        sa = a[ew+mw];
        sb = b[ew+mw] ^ sub;
        ea = int'((a >> mw) & 32'(emax));
        eb = int'((b >> mw) & 32'(emax));
        ma = a & mmask;
        mb = b & mmask;
        if ((ea == emax && ma != 0) || (eb == emax && mb != 0) ||
            (ea == emax && eb == emax && sa != sb))
            return pack(1'b0, emax, 32'd1 << (mw - 1), ew, mw);
        if (ea == emax) return pack(sa, emax, 0, ew, mw);
        if (eb == emax) return pack(sb, emax, 0, ew, mw);
        va = (ea == 0) ? '0 : (((320'(1) << mw) | 320'(ma)) << (ea - 1));
        vb = (eb == 0) ? '0 : (((320'(1) << mw) | 320'(mb)) << (eb - 1));
        if (sa == sb)      begin vr = va + vb; sr = sa; end
        else if (va >= vb) begin vr = va - vb; sr = sa; end
        else               begin vr = vb - va; sr = sb; end
        if (vr == '0) return pack(sa & sb, 0, 0, ew, mw);
        p = 0;
        for (int i = 0; i < 320; i++) if (vr[i]) p = i;
        er = p - mw + 1;
        if (er >= emax) return pack(sr, emax, 0, ew, mw);
        if (er <= 0)    return pack(sr, 0, 0, ew, mw);
        return pack(sr, er, 32'(vr >> (er - 1)) & mmask, ew, mw);
    endfunction

    function automatic logic [31:0] gen_op(input int ew, input int mw);
        logic [31:0] emask, s, e, m;
        emask = (32'd1 << ew) - 1;
        s = 32'($urandom_range(0, 1));
        e = $urandom & emask;
        m = $urandom & ((32'd1 << mw) - 1);
        case ($urandom_range(0, 9))
            0:       begin e = 0; m = 0; end
            1:       e = 0;
            2:       begin e = emask; m = 0; end
            3:       begin e = emask; m = m | 1; end
            4:       e = emask - 32'($urandom_range(1, 2));
            5, 6:    e = (emask >> 1) + 32'($urandom_range(0, 2));
            default: ;
        endcase
        return (s << (ew + mw)) | (e << mw) | m;
    endfunction

    // Near-copies of A give heavy cancellation when subtracted
    function automatic logic [31:0] gen_b(input logic [31:0] a, input int ew, input int mw);
        if ($urandom_range(0, 3) == 0) return a ^ ($urandom & 32'h7);
        return gen_op(ew, mw);
    endfunction

    task automatic run_one(input bit half, input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic [31:0] exp, input string tag);
        int          lat;
        bit          seen;
        logic [31:0] got;
        got  = 'x;
        seen = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        if (half) begin h_valid = 1'b1; h_a = a[15:0]; h_b = b[15:0]; h_sub = sub; end
        else      begin in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; end
        @(negedge clk);
        h_valid  = 1'b0;
        in_valid = 1'b0;
        lat = 1;
        while (lat < 8 && !seen) begin
            seen = half ? h_ovalid : out_valid;
            if (seen) got = half ? {16'h0, h_data} : out_data;
            else begin @(negedge clk); lat++; end
        end
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check(tag, got, exp);
    endtask

    task automatic run_stream(input int mode, input int ncyc);
        logic [31:0] q[$];
        logic [31:0] exp_v, prev_data;
        bit          acc, prev_stall, want;
        int          issued;
        acc = 1'b0; prev_stall = 1'b0; issued = 0; prev_data = '0;
        in_valid = 1'b0;
        for (int c = 0; c < ncyc + 40; c++) begin
            @(negedge clk);
            if (c >= ncyc && q.size() == 0 && !in_valid && !out_valid) break;
            if (!in_valid || acc) begin
                want = (c < ncyc) && ((mode == 0) ? ($urandom_range(0, 3) != 0) : (issued < 5));
                in_valid = want;
                if (want) begin
                    in_a   = gen_op(8, 23);
                    in_b   = gen_b(in_a, 8, 23);
                    in_sub = 1'($urandom_range(0, 1));
                end
            end
            if (c >= ncyc)      out_ready = 1'b1;
            else if (mode == 0) out_ready = ($urandom_range(0, 3) != 0);
            else                out_ready = (c < 2) || (c >= 12);
            #1;
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", out_data, prev_data);
            end
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(ref_add(in_a, in_b, in_sub, 8, 23));
                issued++;
            end
            if (mode == 1 && c == 8) check("bp_in_ready", 32'(in_ready), 32'd0);
            if (mode == 1 && c >= 12 && c <= 16) check("bp_rate", 32'(out_valid), 32'd1);
            if (out_valid && out_ready) begin
                check("pop_ok", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    exp_v = q.pop_front();
                    check("stream", out_data, exp_v);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
        in_valid = 1'b0;
        check("drain_empty", 32'(q.size()), 32'd0);
        if (mode == 1) check("bp_count", 32'(issued), 32'd5);
    endtask

    initial begin
        int          seen_cnt;
        logic [31:0] ra, rb;
        logic        rs;
        rst_n = 1'b0;
        in_valid = 1'b0; in_sub = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        h_valid = 1'b0; h_sub = 1'b0; h_a = '0; h_b = '0; h_oready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_h_data", {16'h0, h_data}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        run_one(0, 32'h3F800000, 32'h3F800000, 0, 32'h40000000, "one_plus_one");
        run_one(0, 32'h40400000, 32'hBF800000, 0, 32'h40000000, "three_minus_one");
        run_one(0, 32'h3FC00000, 32'h3FC00000, 1, 32'h00000000, "cancel");
        run_one(0, 32'h3F800000, 32'h30800000, 1, 32'h3F7FFFFF, "sticky");
        run_one(0, 32'h3F800000, 32'h33800000, 0, 32'h3F800000, "trunc");
        run_one(0, 32'h7F800000, 32'hFF800000, 0, 32'h7FC00000, "inf_minus_inf");
        run_one(0, 32'h7FC00001, 32'h3F800000, 0, 32'h7FC00000, "nan_in");
        run_one(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000, "overflow");
        run_one(0, 32'h00000001, 32'h3F800000, 0, 32'h3F800000, "denormal");
        run_one(0, 32'h80000000, 32'h80000000, 0, 32'h80000000, "neg_zero");
        run_one(0, 32'hBF800000, 32'h00000000, 0, 32'hBF800000, "x_plus_zero");
        run_one(0, 32'h00800000, 32'h00800001, 1, 32'h80000000, "underflow");
        run_one(1, 32'h3C00, 32'h3C00, 0, 32'h4000, "h_one_plus_one");
        run_one(1, 32'h7BFF, 32'h7BFF, 0, 32'h7C00, "h_overflow");
        run_one(1, 32'h3C00, 32'h3C00, 1, 32'h0000, "h_cancel");
        for (int i = 0; i < 40; i++) begin
            ra = gen_op(5, 10);
            rb = gen_b(ra, 5, 10);
            rs = 1'($urandom_range(0, 1));
            run_one(1, ra, rb, rs, ref_add(ra, rb, rs, 5, 10), "h_rand");
        end

        run_stream(0, 600);
        run_stream(1, 20);

        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000; in_sub = 1'b0;
        @(negedge clk);
        in_a = 32'h40400000;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_flight_valid", 32'(out_valid), 32'd0);
        check("rst_flight_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen_cnt++;
        end
        check("rst_flight_lost", 32'(seen_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
